// File: rtl/turn_executor_if.sv
// Signal bundle between the semi-auto command FSM and the turn executor.
// The command FSM is the master; the turn executor is the slave.
interface turn_executor_if;
  logic enable;
  logic trigger_turn_left;
  logic trigger_turn_right;
  logic trigger_turn_back;
  logic move_forward;
  logic is_turning;
  logic out_forward;
  logic out_turn_left;
  logic out_turn_right;
  logic turn_done;

  modport master (
    output enable, trigger_turn_left, trigger_turn_right, trigger_turn_back, move_forward,
    input  is_turning, out_forward, out_turn_left, out_turn_right, turn_done
  );

  modport slave (
    input  enable, trigger_turn_left, trigger_turn_right, trigger_turn_back, move_forward,
    output is_turning, out_forward, out_turn_left, out_turn_right, turn_done
  );
endinterface

// File: rtl/turn_executor.sv
// Executes left/right/back turn requests as timed in-place rotations framed by
// stationary settle pauses, and reports busy/done status upstream.
module turn_executor #(
  parameter int unsigned TURN90_TICKS = 450,
  parameter int unsigned SETTLE_TICKS = 25,
  parameter int unsigned CNT_W        = 16
) (
  input  logic           clk,
  input  logic           rst_n,
  turn_executor_if.slave bus
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PRE  = 2'd1,
    ST_ROT  = 2'd2,
    ST_POST = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    DIR_LEFT  = 2'd0,
    DIR_RIGHT = 2'd1,
    DIR_BACK  = 2'd2
  } dir_t;

  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_TICKS - 1);
  localparam logic [CNT_W-1:0] ROT90_LAST  = CNT_W'(TURN90_TICKS - 1);
  localparam logic [CNT_W-1:0] ROT180_LAST = CNT_W'(2 * TURN90_TICKS - 1);
  localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);

  state_t           state_q, state_d;
  dir_t             dir_q, dir_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             trig_prev_q;
  logic             armed_q;
  logic             is_turning_q, is_turning_d;
  logic             out_forward_q, out_forward_d;
  logic             out_turn_left_q, out_turn_left_d;
  logic             out_turn_right_q, out_turn_right_d;
  logic             turn_done_q, turn_done_d;

  logic             trig_any_s;
  logic             start_s;
  logic [CNT_W-1:0] rot_last_s;

  // armed_q masks the first cycle after reset so a trigger already held at
  // release is absorbed into the history instead of starting a turn.
  assign trig_any_s = bus.trigger_turn_left | bus.trigger_turn_right | bus.trigger_turn_back;
  assign start_s    = trig_any_s & ~trig_prev_q & armed_q;
  assign rot_last_s = (dir_q == DIR_BACK) ? ROT180_LAST : ROT90_LAST;

  always_comb begin
    state_d = state_q;
    dir_d   = dir_q;
    cnt_d   = cnt_q;
    if (!bus.enable) begin
      state_d = ST_IDLE;
      cnt_d   = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start_s) begin
            state_d = ST_PRE;
            cnt_d   = '0;
            if (bus.trigger_turn_back) begin
              dir_d = DIR_BACK;
            end else if (bus.trigger_turn_left) begin
              dir_d = DIR_LEFT;
            end else begin
              dir_d = DIR_RIGHT;
            end
          end else begin
            cnt_d = '0;
          end
        end
        ST_PRE: begin
          if (cnt_q == SETTLE_LAST) begin
            state_d = ST_ROT;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end
        ST_ROT: begin
          if (cnt_q == rot_last_s) begin
            state_d = ST_POST;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end
        ST_POST: begin
          if (cnt_q == SETTLE_LAST) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end
        default: begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end
      endcase
    end

    // Outputs are decoded from the next state so they align with the registered state.
    is_turning_d     = bus.enable & (state_d != ST_IDLE);
    out_forward_d    = bus.enable & (state_d == ST_IDLE) & bus.move_forward;
    out_turn_left_d  = bus.enable & (state_d == ST_ROT) & (dir_d != DIR_RIGHT);
    out_turn_right_d = bus.enable & (state_d == ST_ROT) & (dir_d == DIR_RIGHT);
    turn_done_d      = bus.enable & (state_q == ST_POST) & (state_d == ST_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q          <= ST_IDLE;
      dir_q            <= DIR_LEFT;
      cnt_q            <= '0;
      trig_prev_q      <= 1'b0;
      armed_q          <= 1'b0;
      is_turning_q     <= 1'b0;
      out_forward_q    <= 1'b0;
      out_turn_left_q  <= 1'b0;
      out_turn_right_q <= 1'b0;
      turn_done_q      <= 1'b0;
    end else begin
      state_q          <= state_d;
      dir_q            <= dir_d;
      cnt_q            <= cnt_d;
      trig_prev_q      <= trig_any_s;
      armed_q          <= 1'b1;
      is_turning_q     <= is_turning_d;
      out_forward_q    <= out_forward_d;
      out_turn_left_q  <= out_turn_left_d;
      out_turn_right_q <= out_turn_right_d;
      turn_done_q      <= turn_done_d;
    end
  end

  assign bus.is_turning     = is_turning_q;
  assign bus.out_forward    = out_forward_q;
  assign bus.out_turn_left  = out_turn_left_q;
  assign bus.out_turn_right = out_turn_right_q;
  assign bus.turn_done      = turn_done_q;

endmodule

// File: tb/tb_turn_executor.sv
// Randomized and directed bench for turn_executor; expected outputs come from a
// turn-timeline model and are checked by a decoupled monitor.
module tb_turn_executor;

  localparam int T90 = 8;
  localparam int ST  = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  turn_executor_if bus();

  turn_executor #(
    .TURN90_TICKS(T90),
    .SETTLE_TICKS(ST),
    .CNT_W(16)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus)
  );

  typedef struct packed {
    logic turning;
    logic fwd;
    logic left;
    logic right;
    logic done;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  // Reference model: a turn is a window of positions 1..total inside which the
  // rotation occupies positions ST+1..ST+rot; position 0 means idle.
  logic m_prev = 1'b0;
  logic m_armed = 1'b0;
  logic m_right = 1'b0;
  int   m_pos = 0;
  int   m_rot = 0;
  int   m_total = 0;
  int   m_done_cnt = 0;
  int   dut_done_cnt = 0;

  task automatic model_step(output exp_t e);
    logic trig;
    logic start;
    e = '0;
    if (!rst_n) begin
      m_prev  = 1'b0;
      m_armed = 1'b0;
      m_pos   = 0;
      return;
    end
    trig    = bus.trigger_turn_left | bus.trigger_turn_right | bus.trigger_turn_back;
    start   = trig & ~m_prev & m_armed;
    m_prev  = trig;
    m_armed = 1'b1;
    if (!bus.enable) begin
      m_pos = 0;
    end else if (m_pos == 0) begin
      if (start) begin
        m_right = ~bus.trigger_turn_back & ~bus.trigger_turn_left;
        m_rot   = bus.trigger_turn_back ? 2 * T90 : T90;
        m_total = 2 * ST + m_rot;
        m_pos   = 1;
      end
    end else if (m_pos == m_total) begin
      m_pos  = 0;
      e.done = 1'b1;
      m_done_cnt++;
    end else begin
      m_pos++;
    end
    if (bus.enable && m_pos == 0) e.fwd = bus.move_forward;
    if (m_pos != 0) begin
      e.turning = 1'b1;
      if (m_pos > ST && m_pos <= ST + m_rot) begin
        e.left  = ~m_right;
        e.right = m_right;
      end
    end
  endtask

  task automatic step(input logic en, input logic l, input logic r, input logic b, input logic mf);
    exp_t e;
    bus.enable             = en;
    bus.trigger_turn_left  = l;
    bus.trigger_turn_right = r;
    bus.trigger_turn_back  = b;
    bus.move_forward       = mf;
    @(posedge clk);
    model_step(e);
    exp_q.push_back(e);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  exp_t e_s;
  exp_t a_s;

  // Monitor: every cycle the DUT presents an output vector; compare it with the oldest expectation.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      e_s = exp_q.pop_front();
      a_s = {bus.is_turning, bus.out_forward, bus.out_turn_left, bus.out_turn_right, bus.turn_done};
      checks++;
      if (a_s !== e_s) begin
        errors++;
        $display("FAIL outputs @%0t: got turning=%b fwd=%b left=%b right=%b done=%b, expected turning=%b fwd=%b left=%b right=%b done=%b",
                 $time, a_s.turning, a_s.fwd, a_s.left, a_s.right, a_s.done,
                 e_s.turning, e_s.fwd, e_s.left, e_s.right, e_s.done);
      end
      if (bus.turn_done === 1'b1) dut_done_cnt++;
    end
  end

  initial begin
    logic en, l, r, b, mf;
    mf = 1'b0;
    // Reset with triggers held, then release with them still high.
    for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
    idle(3);
    // Left turn, trigger held 5 cycles.
    for (int i = 0; i < 5; i++) step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    idle(12);
    // Back and left together: back wins.
    step(1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    idle(22);
    // Forward passthrough, right turn while moving.
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    step(1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
    for (int i = 0; i < 16; i++) step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    // Abort mid-rotation, then a full new turn.
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    idle(6);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    idle(1);
    step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    idle(14);
    // Held trigger gives one turn; drop and re-raise gives another.
    for (int i = 0; i < 30; i++) step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    idle(2);
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    idle(14);
    // Start edge with enable low: enable wins.
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    idle(3);
    // Randomized traffic.
    for (int i = 0; i < 1500; i++) begin
      en = ($urandom_range(0, 59) != 0);
      l  = ($urandom_range(0, 11) == 0);
      r  = ($urandom_range(0, 11) == 0);
      b  = ($urandom_range(0, 15) == 0);
      if ($urandom_range(0, 9) == 0) mf = ~mf;
      step(en, l, r, b, mf);
    end
    idle(2);
    @(negedge clk);
    #1;
    checks++;
    if (dut_done_cnt != m_done_cnt) begin
      errors++;
      $display("FAIL done_count: got %0d, expected %0d", dut_done_cnt, m_done_cnt);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
